// File: rtl/alu_sequencer.sv
// Execute-stage sequencer for the shared combinational ALU.
// Runs single-pass ops in one ALU cycle and MUL as WIDTH shift-add steps, and holds the condition codes.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | ready for a request; ALU inputs parked at zero
// EXEC  | one ALU pass with the latched operands and control
// MUL   | shift-add iteration on the ALU adder, WIDTH cycles
// DONE  | one-cycle completion pulse on rsp_valid
module alu_sequencer #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_set_cc,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_of,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_result,
   output logic             cc_zf,
   output logic             cc_sf,
   output logic             cc_of,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t             state_q,  state_d;
   logic [1:0]         ctrl_q,   ctrl_d;
   logic [WIDTH-1:0]   a_q,      a_d;
   logic [WIDTH-1:0]   b_q,      b_d;
   logic [WIDTH-1:0]   acc_q,    acc_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic               set_cc_q, set_cc_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zf_q,     zf_d;
   logic               sf_q,     sf_d;
   logic               of_q,     of_d;

   logic               load_res;
   logic               res_of;

   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      set_cc_d  = set_cc_q;
      result_d  = result_q;
      zf_d      = zf_q;
      sf_d      = sf_q;
      of_d      = of_q;
      alu_a     = '0;
      alu_b     = '0;
      alu_ctrl  = 2'b00;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      load_res  = 1'b0;
      res_of    = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               ctrl_d   = req_op[1:0];
               a_d      = req_a;
               b_d      = req_b;
               set_cc_d = req_set_cc;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = req_op[2] ? S_MUL : S_EXEC;
            end
         end
         S_EXEC: begin
            alu_a    = a_q;
            alu_b    = b_q;
            alu_ctrl = ctrl_q;
            load_res = 1'b1;
            // Only add and sub produce a meaningful signed overflow.
            res_of   = ~ctrl_q[1] & alu_of;
            state_d  = S_DONE;
         end
         S_MUL: begin
            // a_q doubles as the multiplicand and b_q as the multiplier shift register.
            alu_a    = acc_q;
            alu_b    = b_q[0] ? a_q : '0;
            alu_ctrl = 2'b00;
            acc_d    = alu_result;
            a_d      = a_q << 1;
            b_d      = b_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               load_res = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            rsp_valid = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (load_res) begin
         result_d = alu_result;
         if (set_cc_q) begin
            zf_d = (alu_result == '0);
            sf_d = alu_result[WIDTH-1];
            of_d = res_of;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ctrl_q   <= 2'b00;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         set_cc_q <= 1'b0;
         result_q <= '0;
         zf_q     <= 1'b1;
         sf_q     <= 1'b0;
         of_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         set_cc_q <= set_cc_d;
         result_q <= result_d;
         zf_q     <= zf_d;
         sf_q     <= sf_d;
         of_q     <= of_d;
      end
   end

   assign rsp_result = result_q;
   assign cc_zf      = zf_q;
   assign cc_sf      = sf_q;
   assign cc_of      = of_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table of directed ops plus hand sequences
// for reset-during-MUL and back-to-back requests with req_valid held high.
module tb_alu_sequencer;

   localparam int W = 64;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_op;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;
   logic          req_set_cc;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic [1:0]    alu_ctrl;
   logic [W-1:0]  alu_result;
   logic          alu_of;
   logic          rsp_valid;
   logic [W-1:0]  rsp_result;
   logic          cc_zf;
   logic          cc_sf;
   logic          cc_of;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   alu_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_set_cc (req_set_cc),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_of     (alu_of),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .cc_zf      (cc_zf),
      .cc_sf      (cc_sf),
      .cc_of      (cc_of),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model of the shared ALU that the sequencer drives.
   always_comb begin
      alu_result = '0;
      alu_of     = 1'b0;
      case (alu_ctrl)
         2'b00: begin
            alu_result = alu_a + alu_b;
            alu_of = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
         end
         2'b01: begin
            alu_result = alu_a - alu_b;
            alu_of = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
         end
         2'b10: alu_result = alu_a & alu_b;
         default: alu_result = alu_a ^ alu_b;
      endcase
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check64(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checki(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue one request, scramble the inputs right after acceptance, and
   // return the number of cycles from the accept edge to rsp_valid (0 = timeout).
   task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cc, output int lat);
      int w;
      w = 0;
      @(negedge clk);
      while (!req_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      check1("ready_before_issue", req_ready, 1'b1);
      req_valid  = 1'b1;
      req_op     = op;
      req_a      = a;
      req_b      = b;
      req_set_cc = cc;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_op     = 3'($urandom);
      req_a      = {$urandom, $urandom};
      req_b      = {$urandom, $urandom};
      req_set_cc = 1'($urandom);
      lat = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (k == 1) check1("busy_after_accept", busy, 1'b1);
         if (rsp_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cc;
      logic [W-1:0] res;
      logic         zf;
      logic         sf;
      logic         of;
      int           lat;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int lat;
      int seen;

      vecs[0] = '{3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,    1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 2};
      vecs[1] = '{3'b011, 64'hFF,                  64'h0F,   1'b0, 64'hF0,                  1'b0, 1'b1, 1'b1, 2};
      vecs[2] = '{3'b001, 64'd5,                   64'd5,    1'b1, 64'd0,                   1'b1, 1'b0, 1'b0, 2};
      vecs[3] = '{3'b010, 64'hF0,                  64'h0F,   1'b1, 64'd0,                   1'b1, 1'b0, 1'b0, 2};
      vecs[4] = '{3'b001, 64'h8000_0000_0000_0000, 64'd1,    1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 2};
      vecs[5] = '{3'b100, 64'd12,                  64'd13,   1'b1, 64'd156,                 1'b0, 1'b0, 1'b0, 65};
      vecs[6] = '{3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,    1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 65};
      vecs[7] = '{3'b111, 64'h1234,                64'd0,    1'b1, 64'd0,                   1'b1, 1'b0, 1'b0, 65};
      vecs[8] = '{3'b100, 64'h1_0000_0001,         64'h1_0000_0001, 1'b0, 64'h2_0000_0001,  1'b1, 1'b0, 1'b0, 65};
      vecs[9] = '{3'b000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'd0,    1'b1, 1'b0, 1'b1, 2};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_op     = 3'b000;
      req_a      = '0;
      req_b      = '0;
      req_set_cc = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      check1 ("reset_req_ready", req_ready, 1'b1);
      check1 ("reset_busy",      busy,      1'b0);
      check1 ("reset_rsp_valid", rsp_valid, 1'b0);
      check64("reset_rsp_result", rsp_result, 64'd0);
      check1 ("reset_zf", cc_zf, 1'b1);
      check1 ("reset_sf", cc_sf, 1'b0);
      check1 ("reset_of", cc_of, 1'b0);
      check64("idle_alu_a", alu_a, 64'd0);
      check64("idle_alu_b", alu_b, 64'd0);
      check64("idle_alu_ctrl", 64'(alu_ctrl), 64'd0);

      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cc, lat);
         checki ($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check64($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
         check1 ($sformatf("v%0d_zf", i), cc_zf, vecs[i].zf);
         check1 ($sformatf("v%0d_sf", i), cc_sf, vecs[i].sf);
         check1 ($sformatf("v%0d_of", i), cc_of, vecs[i].of);
         @(negedge clk);
         check1 ($sformatf("v%0d_pulse_one_cycle", i), rsp_valid, 1'b0);
         check1 ($sformatf("v%0d_ready_after", i), req_ready, 1'b1);
      end

      // Reset in the middle of a MUL: abort, no response, CC back to reset values.
      do_op(3'b000, 64'd1, 64'd1, 1'b1, lat);
      check64("pre_abort_result", rsp_result, 64'd2);
      check1 ("pre_abort_zf", cc_zf, 1'b0);
      @(negedge clk);
      req_valid  = 1'b1;
      req_op     = 3'b100;
      req_a      = 64'd7;
      req_b      = 64'd9;
      req_set_cc = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 19; k++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check1 ("abort_ready_after_rst", req_ready, 1'b1);
      check1 ("abort_busy_after_rst",  busy,      1'b0);
      check64("abort_result_cleared",  rsp_result, 64'd0);
      check1 ("abort_zf", cc_zf, 1'b1);
      check1 ("abort_sf", cc_sf, 1'b0);
      check1 ("abort_of", cc_of, 1'b0);
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      checki("abort_no_rsp_valid", seen, 0);
      do_op(3'b000, 64'd2, 64'd3, 1'b1, lat);
      checki ("post_abort_latency", lat, 2);
      check64("post_abort_result", rsp_result, 64'd5);
      check1 ("post_abort_zf", cc_zf, 1'b0);

      // req_valid held high: second ADD waits for IDLE; operand changes while busy are ignored.
      @(negedge clk);
      req_valid  = 1'b1;
      req_op     = 3'b000;
      req_a      = 64'd10;
      req_b      = 64'd20;
      req_set_cc = 1'b0;
      @(posedge clk);
      #1;
      req_a = 64'd100;
      req_b = 64'd200;
      @(negedge clk);
      check1 ("held_not_ready_exec", req_ready, 1'b0);
      @(negedge clk);
      check1 ("held_first_rsp_valid", rsp_valid, 1'b1);
      check1 ("held_not_ready_done", req_ready, 1'b0);
      check64("held_first_result", rsp_result, 64'd30);
      @(negedge clk);
      check1 ("held_ready_again", req_ready, 1'b1);
      @(negedge clk);
      check1 ("held_second_accepted", busy, 1'b1);
      req_valid = 1'b0;
      req_a     = 64'd5000;
      @(negedge clk);
      check1 ("held_second_rsp_valid", rsp_valid, 1'b1);
      check64("held_second_result", rsp_result, 64'd300);
      @(negedge clk);
      check1 ("held_idle_final", req_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
